// File: rtl/multiplier_pkg.sv
// Shared definitions for the multiplier sequencer and its datapath.
//   state_t       : sequencer FSM states
//   DEFAULT_WIDTH : default operand width in bits
package multiplier_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/multiplier_datapath.sv
// Shift-add unsigned multiplier datapath.
// Ports:
//   clock, n_reset : clock and asynchronous active-low reset
//   do_init        : load multiplicand and seed the accumulator with the multiplier
//   do_shift       : one add-and-shift step (N steps give the full product)
//   multiplicand   : operand A (N bits)
//   multiplier     : operand B (N bits)
//   product        : accumulator contents, A*B after N shift steps (2N bits)
module multiplier_datapath
    import multiplier_pkg::*;
#(
    parameter int unsigned N = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             n_reset,
    input  logic             do_init,
    input  logic             do_shift,
    input  logic [N-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
    output logic [2*N-1:0]   product
);

    logic [N-1:0]   mcand_q;
    logic [2*N-1:0] acc_q, acc_d;
    logic [N:0]     sum;

    // Upper half accumulates partial products; lower half holds the multiplier
    // bits not yet consumed, LSB first.
    always_comb begin
        sum   = {1'b0, acc_q[2*N-1:N]} + {1'b0, (acc_q[0] ? mcand_q : {N{1'b0}})};
        acc_d = acc_q;
        if (do_init) begin
            acc_d = {{N{1'b0}}, multiplier};
        end else if (do_shift) begin
            acc_d = {sum, acc_q[N-1:1]};
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            mcand_q <= '0;
            acc_q   <= '0;
        end else begin
            if (do_init) begin
                mcand_q <= multiplicand;
            end
            acc_q <= acc_d;
        end
    end

    assign product = acc_q;

endmodule

// File: rtl/multiplier_sequencer.sv
// Sequencer for an N-bit unsigned shift-add multiplier with valid/ready handshakes.
// Ports:
//   clock, n_reset            : clock and asynchronous active-low reset
//   start_valid, start_ready  : operand handshake (accepted only in IDLE)
//   multiplicand, multiplier  : operands, registered on accept
//   result_valid, result_ready: result handshake (held in DONE until taken)
//   product                   : 2N-bit unsigned product
// Optional feature: define MULTIPLIER_SEQUENCER_ZERO_SKIP_EN to jump straight to
// DONE with product 0 when either operand is zero.
module multiplier_sequencer
    import multiplier_pkg::*;
#(
    parameter int unsigned N = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             n_reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [N-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [2*N-1:0]   product
);

    localparam int unsigned CW = $clog2(N);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   op_a_q, op_b_q;
    logic           accept;
    logic           do_init, do_shift;
    logic [2*N-1:0] dp_product;

    assign start_ready = (state_q == IDLE);
    assign accept      = start_valid && start_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        do_init      = 1'b0;
        do_shift     = 1'b0;
        result_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef MULTIPLIER_SEQUENCER_ZERO_SKIP_EN
                    if (multiplicand == '0 || multiplier == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = INIT;
                    end
`else
                    state_d = INIT;
`endif
                end
            end
            INIT: begin
                do_init = 1'b1;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                do_shift = 1'b1;
                // Leave on the Nth shift; clearing here keeps the counter from wrapping.
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_a_q <= multiplicand;
                op_b_q <= multiplier;
            end
        end
    end

    multiplier_datapath #(
        .N (N)
    ) u_datapath (
        .clock        (clock),
        .n_reset      (n_reset),
        .do_init      (do_init),
        .do_shift     (do_shift),
        .multiplicand (op_a_q),
        .multiplier   (op_b_q),
        .product      (dp_product)
    );

`ifdef MULTIPLIER_SEQUENCER_ZERO_SKIP_EN
    // Skipped operations never touch the accumulator, so its stale value is masked.
    logic skip_q;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            skip_q <= 1'b0;
        end else if (accept) begin
            skip_q <= (multiplicand == '0 || multiplier == '0);
        end
    end

    assign product = skip_q ? '0 : dp_product;
`else
    assign product = dp_product;
`endif

endmodule

// File: doc/multiplier_sequencer.md
MULTIPLIER_SEQUENCER -- requirements
Module: multiplier_sequencer

Interface
REQ-001 SHALL have parameter N, default 4, giving the operand width in bits (N >= 2).
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port n_reset, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start_valid, input, 1 bit: the requester presents operands.
REQ-005 SHALL have port start_ready, output, 1 bit: the sequencer can accept operands.
REQ-006 SHALL have port multiplicand, input, N bits: operand A, sampled on accept.
REQ-007 SHALL have port multiplier, input, N bits: operand B, sampled on accept.
REQ-008 SHALL have port result_valid, output, 1 bit: product is valid.
REQ-009 SHALL have port result_ready, input, 1 bit: the consumer takes the product.
REQ-010 SHALL have port product, output, 2N bits: the unsigned product.

Function
REQ-011 SHALL implement FSM states IDLE, INIT, SHIFT, DONE.
REQ-012 SHALL drive start_ready=1 only in IDLE; accept occurs on an edge with start_valid && start_ready.
REQ-013 SHALL, on accept, register multiplicand and multiplier into internal operand registers and go IDLE->INIT.
REQ-014 SHALL, in INIT, assert datapath do_init for exactly one cycle using the registered operands, then go INIT->SHIFT with the shift counter at 0.
REQ-015 SHALL, in SHIFT, assert do_shift every cycle, increment the counter each edge, and go SHIFT->DONE on the edge where the counter reaches N-1 (exactly N shifts).
REQ-016 SHALL never assert do_init and do_shift together; both SHALL be 0 in IDLE and DONE.
REQ-017 SHALL assert result_valid only in DONE, with product = A*B (unsigned, full 2N bits, no truncation).
REQ-018 SHALL hold result_valid and product stable in DONE until result_ready=1, then go DONE->IDLE on that edge.
REQ-019 SHALL give a latency of N+1 edges from the accept edge to result_valid=1 (5 for N=4) when the zero-skip feature is not taken.
REQ-020 SHALL ignore start_valid and input operand changes outside IDLE; a new operation SHALL NOT be accepted in the same cycle as the result handshake.
REQ-021 SHALL feed the datapath only from the registered operands, never directly from the input ports.
REQ-022 SHALL size the counter $clog2(N) bits; it SHALL NOT wrap within an operation.

Reset
REQ-023 SHALL, while n_reset=0, force state=IDLE, counter=0, operand registers=0, start_ready=1, result_valid=0 and product=0, asynchronously.
REQ-024 SHALL, on reset assertion mid-operation (INIT/SHIFT/DONE), abandon the operation; after release the block SHALL be in IDLE with no spurious result_valid.
REQ-025 SHALL tie n_reset directly to the datapath reset.

Configuration
REQ-026 SHALL, with MULTIPLIER_SEQUENCER_ZERO_SKIP_EN defined, go directly IDLE->DONE on accept when either operand is 0, present product=0, and issue no do_init or do_shift (latency 1).
REQ-027 SHALL, without MULTIPLIER_SEQUENCER_ZERO_SKIP_EN, process zero operands through the full INIT/SHIFT sequence (latency N+1, product 0).

Structure
REQ-028 SHALL place the FSM state enum typedef and the default width constant (4) in shared package multiplier_pkg.
REQ-029 SHALL instantiate exactly one sub-module, multiplier_datapath (ports clock, n_reset, do_init, do_shift, multiplicand, multiplier, product), with its product as the output source.

Verification
REQ-030 Bench SHALL check: 11*6 accepted with result_ready=1 -> result_valid rises 5 edges after accept with product=66, returns to IDLE next edge.
REQ-031 Bench SHALL check: 15*15 with result_ready=0 for 10 cycles -> product=225 and result_valid held steady, then cleared one edge after result_ready=1.
REQ-032 Bench SHALL check: start_valid with 3*3 asserted during SHIFT of 11*6 -> start_ready=0, ignored, product=66; 3*3 is accepted only after return to IDLE -> 9.
REQ-033 Bench SHALL check: n_reset pulsed low during SHIFT -> result_valid=0, product=0, start_ready=1 immediately; subsequent 7*5 -> 35.
REQ-034 Bench SHALL check: 0*9 -> with the macro, product=0 after 1 edge and no do_init/do_shift; without it, product=0 after 5 edges.
REQ-035 Bench SHALL check: during each operation, do_init is high exactly 1 cycle and do_shift exactly N cycles, never overlapping.
